// File: rtl/wt_dcache_miss_arb_pkg.sv
// Shared types and sizing constants for the write-through dcache miss path.
package wt_cache_pkg;

    localparam int unsigned CACHE_ID_WIDTH   = 4;
    localparam int unsigned DCACHE_SET_ASSOC = 8;
    localparam int unsigned NumPortsDefault  = 3;

    // Two-state lock machine used by the miss arbiter.
    typedef enum logic {
        MissArbIdle,
        MissArbLocked
    } miss_arb_state_e;

    // Minimal stand-in for the core configuration record; only passed through.
    typedef struct packed {
        logic [63:0] CachedRegionAddrBase;
        logic [63:0] CachedRegionLength;
    } ariane_cfg_t;

    localparam ariane_cfg_t ArianeDefaultConfig = '{
        CachedRegionAddrBase: 64'h0000_0000_8000_0000,
        CachedRegionLength:   64'h0000_0000_4000_0000
    };

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wt_dcache_rr_sel.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping.
module wt_dcache_rr_sel
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumIn = 3,
    parameter int unsigned IdxW  = idxWidth(NumIn)
) (
    input  logic [NumIn-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic             vld_o,
    output logic [IdxW-1:0]  idx_o
);

    int unsigned     cand;
    logic [IdxW-1:0] candIdx;

    // Walk the ports starting at the pointer and keep the first requester found.
    always_comb begin
        vld_o   = 1'b0;
        idx_o   = '0;
        cand    = 0;
        candIdx = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            candIdx = IdxW'(cand);
            if (!vld_o && req_i[candIdx]) begin
                vld_o = 1'b1;
                idx_o = candIdx;
            end
        end
    end

endmodule

// File: rtl/wt_dcache_miss_arb.sv
// Arbitrates dcache read-controller misses onto the single miss-unit request
// port and routes miss-unit completions back to the ports that own them.
module wt_dcache_miss_arb
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumPorts  = NumPortsDefault,
    parameter ariane_cfg_t ArianeCfg = ArianeDefaultConfig
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NumPorts-1:0]                        miss_req_i,
    output logic [NumPorts-1:0]                        miss_ack_o,
    output logic [NumPorts-1:0]                        miss_replay_o,
    output logic [NumPorts-1:0]                        miss_rtrn_vld_o,
    input  logic [NumPorts-1:0][63:0]                  miss_paddr_i,
    input  logic [NumPorts-1:0][2:0]                   miss_size_i,
    input  logic [NumPorts-1:0]                        miss_nc_i,
    input  logic [NumPorts-1:0]                        miss_approx_i,
    input  logic [NumPorts-1:0][DCACHE_SET_ASSOC-1:0]  miss_vld_bits_i,
    input  logic [NumPorts-1:0][CACHE_ID_WIDTH-1:0]    miss_id_i,
    output logic                                       mu_req_o,
    output logic [63:0]                                mu_paddr_o,
    output logic [2:0]                                 mu_size_o,
    output logic                                       mu_nc_o,
    output logic                                       mu_approx_o,
    output logic [DCACHE_SET_ASSOC-1:0]                mu_vld_bits_o,
    output logic [CACHE_ID_WIDTH-1:0]                  mu_id_o,
    input  logic                                       mu_ack_i,
    input  logic                                       mu_replay_i,
    input  logic                                       mu_rtrn_vld_i,
    input  logic [CACHE_ID_WIDTH-1:0]                  mu_rtrn_id_i,
    output logic                                       err_unexp_rtrn_o
);

    localparam int unsigned IdxW = idxWidth(NumPorts);

    // The configuration record is only carried for interface compatibility.
    if (ArianeCfg.CachedRegionLength == 64'd0) begin : gen_cfg_no_cached_region
    end

    miss_arb_state_e       state_q, state_d;
    logic [IdxW-1:0]       sel_q, sel_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NumPorts-1:0]   outstanding_q, outstanding_d;
    logic                  err_q, err_d;

    logic [NumPorts-1:0]   eligible;
    logic                  rrVld;
    logic [IdxW-1:0]       rrIdx;
    logic [IdxW-1:0]       sel;
    logic [IdxW-1:0]       nextPtr;
    logic                  selReq;
    logic [NumPorts-1:0]   ackVec;
    logic [NumPorts-1:0]   replayVec;
    logic [NumPorts-1:0]   rtrnMatch;

    // Gating with rst_ni keeps every request-path output low while reset is
    // asserted; the rest of the state is already cleared by the flops.
    assign eligible = miss_req_i & ~outstanding_q & {NumPorts{rst_ni}};

    wt_dcache_rr_sel #(
        .NumIn (NumPorts),
        .IdxW  (IdxW)
    ) i_rr_sel (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .vld_o (rrVld),
        .idx_o (rrIdx)
    );

    assign nextPtr = (sel == IdxW'(NumPorts - 1)) ? '0 : sel + IdxW'(1);

    // Lock FSM: grant in IDLE with zero latency, hold the winner while it waits.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        sel       = sel_q;
        selReq    = 1'b0;
        ackVec    = '0;
        replayVec = '0;
        case (state_q)
            MissArbIdle: begin
                sel    = rrIdx;
                selReq = rrVld;
            end
            MissArbLocked: begin
                sel    = sel_q;
                selReq = miss_req_i[sel_q] & rst_ni;
                if (!selReq) begin
                    state_d = MissArbIdle;
                end
            end
            default: state_d = MissArbIdle;
        endcase
        if (selReq) begin
            if (mu_replay_i) begin
                replayVec[sel] = 1'b1;
                state_d        = MissArbIdle;
                rr_ptr_d       = nextPtr;
            end else if (mu_ack_i) begin
                ackVec[sel] = 1'b1;
                state_d     = MissArbIdle;
                rr_ptr_d    = nextPtr;
            end else begin
                state_d = MissArbLocked;
                sel_d   = sel;
            end
        end
    end

    // Forward the selected port's request fields, zero when nothing is selected.
    always_comb begin
        mu_req_o      = selReq;
        mu_paddr_o    = '0;
        mu_size_o     = '0;
        mu_nc_o       = 1'b0;
        mu_approx_o   = 1'b0;
        mu_vld_bits_o = '0;
        mu_id_o       = '0;
        if (selReq) begin
            mu_paddr_o    = miss_paddr_i[sel];
            mu_size_o     = miss_size_i[sel];
            mu_nc_o       = miss_nc_i[sel];
            mu_approx_o   = miss_approx_i[sel];
            mu_vld_bits_o = miss_vld_bits_i[sel];
            mu_id_o       = miss_id_i[sel];
        end
    end

    // Match returns against outstanding IDs; a new ack wins over a same-cycle clear.
    always_comb begin
        rtrnMatch = '0;
        for (int i = 0; i < NumPorts; i++) begin
            rtrnMatch[i] = mu_rtrn_vld_i && outstanding_q[i] && (miss_id_i[i] == mu_rtrn_id_i);
        end
        outstanding_d = (outstanding_q & ~rtrnMatch) | ackVec;
        err_d         = err_q | (mu_rtrn_vld_i & ~(|rtrnMatch));
    end

    assign miss_ack_o       = ackVec;
    assign miss_replay_o    = replayVec;
    assign miss_rtrn_vld_o  = rtrnMatch;
    assign err_unexp_rtrn_o = err_q;

    // State registers; reset drops any lock in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= MissArbIdle;
            sel_q         <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// Self-checking bench for the dcache miss arbiter: a table of per-cycle
// vectors plus hand-written reset and wait-state sequences.
module tb_wt_dcache_miss_arb;
    import wt_cache_pkg::*;

    localparam int NP = 3;

    typedef struct {
        int          tag;
        logic [2:0]  req;
        logic        ack;
        logic        rep;
        logic        rv;
        logic [3:0]  rid;
        logic        expMuReq;
        int          expSel;
        logic [2:0]  expAck;
        logic [2:0]  expRep;
        logic [2:0]  expRtrn;
        logic        expErr;
    } vec_t;

    logic                         clk;
    logic                         rstN;
    logic [NP-1:0]                missReq;
    logic [NP-1:0]                missAck, missReplay, missRtrnVld;
    logic [NP-1:0][63:0]          missPaddr;
    logic [NP-1:0][2:0]           missSize;
    logic [NP-1:0]                missNc, missApprox;
    logic [NP-1:0][7:0]           missVldBits;
    logic [NP-1:0][3:0]           missId;
    logic                         muReq;
    logic [63:0]                  muPaddr;
    logic [2:0]                   muSize;
    logic                         muNc, muApprox;
    logic [7:0]                   muVldBits;
    logic [3:0]                   muId;
    logic                         muAck, muReplay, muRtrnVld;
    logic [3:0]                   muRtrnId;
    logic                         errUnexp;

    int   compared   = 0;
    int   mismatched = 0;
    int   vecCount   = 0;
    vec_t expQ[$];
    vec_t tbl[18];

    wt_dcache_miss_arb #(.NumPorts(NP)) dut (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .miss_req_i       (missReq),
        .miss_ack_o       (missAck),
        .miss_replay_o    (missReplay),
        .miss_rtrn_vld_o  (missRtrnVld),
        .miss_paddr_i     (missPaddr),
        .miss_size_i      (missSize),
        .miss_nc_i        (missNc),
        .miss_approx_i    (missApprox),
        .miss_vld_bits_i  (missVldBits),
        .miss_id_i        (missId),
        .mu_req_o         (muReq),
        .mu_paddr_o       (muPaddr),
        .mu_size_o        (muSize),
        .mu_nc_o          (muNc),
        .mu_approx_o      (muApprox),
        .mu_vld_bits_o    (muVldBits),
        .mu_id_o          (muId),
        .mu_ack_i         (muAck),
        .mu_replay_i      (muReplay),
        .mu_rtrn_vld_i    (muRtrnVld),
        .mu_rtrn_id_i     (muRtrnId),
        .err_unexp_rtrn_o (errUnexp)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [2:0] req, input logic ack, input logic rep,
                                input logic rv, input logic [3:0] rid, input logic muR,
                                input int sel, input logic [2:0] eAck, input logic [2:0] eRep,
                                input logic [2:0] eRtrn, input logic eErr);
        vec_t v;
        v.tag = 0; v.req = req; v.ack = ack; v.rep = rep; v.rv = rv; v.rid = rid;
        v.expMuReq = muR; v.expSel = sel; v.expAck = eAck; v.expRep = eRep;
        v.expRtrn = eRtrn; v.expErr = eErr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue its expectation.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        missReq   = v.req;
        muAck     = v.ack;
        muReplay  = v.rep;
        muRtrnVld = v.rv;
        muRtrnId  = v.rid;
        v.tag     = vecCount;
        vecCount++;
        expQ.push_back(v);
        #2;
        checkOutput();
    endtask

    // Pop the oldest expectation and compare it with the settled outputs.
    task automatic checkOutput();
        vec_t        e;
        logic [63:0] ePaddr;
        logic [2:0]  eSize;
        logic [7:0]  eVld;
        logic [3:0]  eId;
        logic        eNc, eApprox;
        string       p;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: queue empty, expected 1 entry");
            return;
        end
        e = expQ.pop_front();
        p = $sformatf("v%0d", e.tag);
        ePaddr = '0; eSize = '0; eVld = '0; eId = '0; eNc = 1'b0; eApprox = 1'b0;
        if (e.expMuReq) begin
            ePaddr  = 64'hA000_0000 + 64'(e.expSel) * 64'h40;
            eSize   = 3'(e.expSel + 1);
            eVld    = 8'(1 << e.expSel);
            eId     = 4'(e.expSel + 1);
            eNc     = (e.expSel == 1);
            eApprox = (e.expSel == 2);
        end
        check({p, ".mu_req"},   64'(muReq),       64'(e.expMuReq));
        check({p, ".mu_paddr"}, muPaddr,          ePaddr);
        check({p, ".mu_size"},  64'(muSize),      64'(eSize));
        check({p, ".mu_vld"},   64'(muVldBits),   64'(eVld));
        check({p, ".mu_id"},    64'(muId),        64'(eId));
        check({p, ".mu_nc"},    64'({muNc, muApprox}), 64'({eNc, eApprox}));
        check({p, ".ack"},      64'(missAck),     64'(e.expAck));
        check({p, ".replay"},   64'(missReplay),  64'(e.expRep));
        check({p, ".rtrn"},     64'(missRtrnVld), 64'(e.expRtrn));
        check({p, ".err"},      64'(errUnexp),    64'(e.expErr));
    endtask

    task automatic checkReset(input string p);
        check({p, ".mu_req"},   64'(muReq),       64'd0);
        check({p, ".mu_paddr"}, muPaddr,          64'd0);
        check({p, ".mu_id"},    64'(muId),        64'd0);
        check({p, ".ack"},      64'(missAck),     64'd0);
        check({p, ".replay"},   64'(missReplay),  64'd0);
        check({p, ".rtrn"},     64'(missRtrnVld), 64'd0);
        check({p, ".err"},      64'(errUnexp),    64'd0);
    endtask

    initial begin
        // Per-cycle vectors: req ack rep rv rid | muReq sel ack rep rtrn err
        tbl[0]  = mk(3'b111, 1, 0, 0, 4'd0, 1, 0, 3'b001, 3'b000, 3'b000, 0);
        tbl[1]  = mk(3'b110, 1, 0, 0, 4'd0, 1, 1, 3'b010, 3'b000, 3'b000, 0);
        tbl[2]  = mk(3'b100, 1, 0, 0, 4'd0, 1, 2, 3'b100, 3'b000, 3'b000, 0);
        tbl[3]  = mk(3'b000, 0, 0, 1, 4'd1, 0, 0, 3'b000, 3'b000, 3'b001, 0);
        tbl[4]  = mk(3'b001, 0, 0, 0, 4'd0, 1, 0, 3'b000, 3'b000, 3'b000, 0);
        tbl[5]  = mk(3'b001, 1, 0, 0, 4'd0, 1, 0, 3'b001, 3'b000, 3'b000, 0);
        tbl[6]  = mk(3'b000, 0, 0, 1, 4'd2, 0, 0, 3'b000, 3'b000, 3'b010, 0);
        tbl[7]  = mk(3'b000, 0, 0, 1, 4'd3, 0, 0, 3'b000, 3'b000, 3'b100, 0);
        tbl[8]  = mk(3'b000, 0, 0, 1, 4'd1, 0, 0, 3'b000, 3'b000, 3'b001, 0);
        tbl[9]  = mk(3'b000, 0, 0, 1, 4'd5, 0, 0, 3'b000, 3'b000, 3'b000, 0);
        tbl[10] = mk(3'b000, 0, 0, 0, 4'd0, 0, 0, 3'b000, 3'b000, 3'b000, 1);
        tbl[11] = mk(3'b100, 1, 1, 0, 4'd0, 1, 2, 3'b000, 3'b100, 3'b000, 1);
        tbl[12] = mk(3'b100, 0, 0, 0, 4'd0, 1, 2, 3'b000, 3'b000, 3'b000, 1);
        tbl[13] = mk(3'b000, 0, 0, 0, 4'd0, 0, 0, 3'b000, 3'b000, 3'b000, 1);
        tbl[14] = mk(3'b100, 1, 0, 0, 4'd0, 1, 2, 3'b100, 3'b000, 3'b000, 1);
        tbl[15] = mk(3'b100, 1, 0, 0, 4'd0, 0, 0, 3'b000, 3'b000, 3'b000, 1);
        tbl[16] = mk(3'b100, 0, 0, 1, 4'd3, 0, 0, 3'b000, 3'b000, 3'b100, 1);
        tbl[17] = mk(3'b100, 1, 0, 0, 4'd0, 1, 2, 3'b100, 3'b000, 3'b000, 1);

        for (int i = 0; i < NP; i++) begin
            missPaddr[i]   = 64'hA000_0000 + 64'(i) * 64'h40;
            missSize[i]    = 3'(i + 1);
            missNc[i]      = (i == 1);
            missApprox[i]  = (i == 2);
            missVldBits[i] = 8'(1 << i);
            missId[i]      = 4'(i + 1);
        end

        // Reset with requests pending: all outputs must stay low.
        rstN      = 1'b0;
        missReq   = 3'b111;
        muAck     = 1'b1;
        muReplay  = 1'b0;
        muRtrnVld = 1'b0;
        muRtrnId  = 4'd0;
        #3;
        checkReset("reset0");
        missReq = 3'b000;
        muAck   = 1'b0;
        #9;
        rstN = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i]);
        end

        // Clear port 2, then port 1 waits three cycles before the ack.
        applyStimulus(mk(3'b000, 0, 0, 1, 4'd3, 0, 0, 3'b000, 3'b000, 3'b100, 1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(3'b010, 0, 0, 0, 4'd0, 1, 1, 3'b000, 3'b000, 3'b000, 1));
        end
        applyStimulus(mk(3'b010, 1, 0, 0, 4'd0, 1, 1, 3'b010, 3'b000, 3'b000, 1));
        applyStimulus(mk(3'b000, 0, 0, 1, 4'd2, 0, 0, 3'b000, 3'b000, 3'b010, 1));

        // Lock onto port 1, then reset mid-transaction.
        applyStimulus(mk(3'b010, 0, 0, 0, 4'd0, 1, 1, 3'b000, 3'b000, 3'b000, 1));
        @(posedge clk);
        #1;
        missReq = 3'b011;
        muAck   = 1'b0;
        rstN    = 1'b0;
        #1;
        checkReset("reset1");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(mk(3'b011, 1, 0, 0, 4'd0, 1, 0, 3'b001, 3'b000, 3'b000, 0));
        applyStimulus(mk(3'b011, 1, 0, 0, 4'd0, 1, 1, 3'b010, 3'b000, 3'b000, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wt_dcache_miss_arb.md
WT_DCACHE_MISS_ARB -- requirements
Module: wt_dcache_miss_arb

Interface
REQ-001 SHALL have parameter NumPorts, default 3, number of dcache read controllers arbitrated.
REQ-002 SHALL have parameter ArianeCfg, default ariane_pkg::ArianeDefaultConfig, carried through for consistency (unused internally).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 miss_req_i  in  NumPorts  per-port miss request, held until ack or replay.
REQ-006 miss_ack_o  out  NumPorts  per-port acceptance, one cycle.
REQ-007 miss_replay_o  out  NumPorts  per-port replay indication, one cycle.
REQ-008 miss_rtrn_vld_o  out  NumPorts  per-port miss-served pulse.
REQ-009 miss_paddr_i / miss_size_i / miss_nc_i / miss_approx_i  in  NumPorts x 64 / 3 / 1 / 1  per-port request fields.
REQ-010 miss_vld_bits_i  in  NumPorts x DCACHE_SET_ASSOC  per-port valid bits at missed index.
REQ-011 miss_id_i  in  NumPorts x CACHE_ID_WIDTH  per-port constant transaction ID.
REQ-012 mu_req_o, mu_paddr_o, mu_size_o, mu_nc_o, mu_approx_o, mu_vld_bits_o, mu_id_o  out  fields as above  single request to miss unit.
REQ-013 mu_ack_i, mu_replay_i  in  1 each  miss-unit accept / replay for current request.
REQ-014 mu_rtrn_vld_i  in  1; mu_rtrn_id_i  in  CACHE_ID_WIDTH  miss-unit completion and its ID.
REQ-015 err_unexp_rtrn_o  out  1  sticky: return with no matching outstanding port.

Function
REQ-016 eligible[i] SHALL be miss_req_i[i] AND NOT outstanding_q[i].
REQ-017 FSM states IDLE, LOCKED; IDLE with any eligible selects winner by round-robin starting at rr_ptr_q, drives mu_req_o=1 with winner fields same cycle (zero-latency).
REQ-018 In IDLE, if mu_ack_i or mu_replay_i arrives same cycle, handshake completes without entering LOCKED; else go LOCKED storing winner in sel_q.
REQ-019 In LOCKED, mu_req_o SHALL be driven from port sel_q only; other ports see no ack/replay.
REQ-020 mu_ack_i in LOCKED/IDLE-grant SHALL pulse miss_ack_o[sel], set outstanding_q[sel], return to IDLE.
REQ-021 mu_replay_i SHALL pulse miss_replay_o[sel], leave outstanding_q unchanged, return to IDLE; replay has priority if both asserted.
REQ-022 On ack or replay rr_ptr_q SHALL advance to sel+1, wrapping NumPorts-1 -> 0.
REQ-023 If miss_req_i[sel_q] drops in LOCKED without handshake, SHALL return to IDLE, mu_req_o deasserted that cycle.
REQ-024 mu_rtrn_vld_i SHALL pulse miss_rtrn_vld_o[i] for every i with outstanding_q[i] and miss_id_i[i]==mu_rtrn_id_i, clearing those bits, same cycle (combinational).
REQ-025 Return with no match SHALL set err_unexp_rtrn_o and be dropped.
REQ-026 Return and ack for same port same cycle: clear then set, outstanding_q ends 1.
REQ-027 All outputs SHALL be 0 when no request selected; mu_id_o equals selected port's miss_id_i.

Reset
REQ-028 On rst_ni low: state IDLE, rr_ptr_q=0, sel_q=0, outstanding_q=0, err_unexp_rtrn_o=0; all outputs 0 immediately; mid-transaction lock discarded.

Structure
REQ-029 State enum and NumPorts default SHALL live in wt_cache_pkg; CACHE_ID_WIDTH, DCACHE_SET_ASSOC from wt_cache_pkg/ariane_pkg.
REQ-030 Round-robin pick SHALL be a sub-module rr_arb_tree-style instance named wt_dcache_rr_sel (request vector, pointer in, one-hot/index out).

Verification
REQ-031 Ports 0,1,2 request simultaneously, mu_ack_i=1 each cycle -> acks to 0,1,2 in consecutive cycles, rr_ptr 1,2,0.
REQ-032 Port 1 requests, mu_ack_i low 3 cycles then high -> mu_req_o held 4 cycles with port-1 paddr, single miss_ack_o[1] pulse.
REQ-033 Port 0 acked (ID 1), mu_rtrn_vld_i with id=1 -> miss_rtrn_vld_o=3'b001, outstanding cleared; port 0 re-request then eligible.
REQ-034 mu_replay_i and mu_ack_i both high for port 2 -> miss_replay_o[2]=1, miss_ack_o=0, outstanding_q[2]=0.
REQ-035 mu_rtrn_vld_i id=5 with nothing outstanding -> no rtrn pulse, err_unexp_rtrn_o=1 sticky.
REQ-036 rst_ni low while LOCKED on port 1 -> all outputs 0 asynchronously, after release port 0 wins first.
